keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 50000, meaning clk cycles each column is driven before its rows are sampled (must be at least 4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, meaning clk cycles a row pattern must stay stable to be accepted as a press or a release (must be at least 2).
REQ-003 Port clk, input, 1 bit: the single system clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset; asserting 0 clears all state immediately.
REQ-005 Port rows_n, input, 4 bits: keypad row lines, pulled up, active-low, asynchronous to clk.
REQ-006 Port cols_n, output, 4 bits: keypad column drive, one-cold, active-low.
REQ-007 Port key, output, 8 bits: last accepted key; key[7:4] is the one-hot row (row r = bit 4+r), key[3:0] is the one-hot column (column c = bit c); this is the code the downstream key-to-digit converter consumes.
REQ-008 Port key_valid, output, 1 bit: single-cycle strobe marking a newly accepted press.
REQ-009 Port key_held, output, 1 bit: level, high from the key_valid cycle until release debounce completes.

Function
REQ-010 rows_n shall pass through a 2-flop synchronizer (reset value 4'b1111) before any use; "row pattern" below means the synchronized, inverted value.
REQ-011 The FSM shall have exactly the states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-012 In SCAN, a dwell counter shall run from 0 to SCAN_CYCLES-1 on the active column and sample the row pattern at SCAN_CYCLES-1.
REQ-013 In SCAN, a sample with exactly one row bit set shall capture {row one-hot, active column one-hot} internally, clear the counter and enter DEBOUNCE with cols_n frozen.
REQ-014 In SCAN, a sample with zero bits or two or more bits set shall advance the column (0->1->2->3->0) and restart the dwell.
REQ-015 In DEBOUNCE, the counter shall increment each cycle the row pattern equals the captured row; any mismatch shall return to SCAN and advance to the next column with no output change.
REQ-016 In DEBOUNCE, when the counter reaches DEBOUNCE_CYCLES-1 with a match, the next cycle shall load key with the captured code, pulse key_valid high for exactly one cycle, set key_held and enter HELD.
REQ-017 In HELD, the column shall stay frozen; a row pattern of zero shall enter RELEASE with the counter cleared; all other patterns, including extra keys, shall be ignored.
REQ-018 In RELEASE, DEBOUNCE_CYCLES consecutive all-zero cycles shall clear key_held and enter SCAN on the next column; any nonzero pattern shall return to HELD with no key_valid pulse.
REQ-019 key shall hold its value between strobes and shall not change outside the key_valid cycle.
REQ-020 Counters shall be sized with $clog2 of their parameter and shall never wrap within a state.

Reset
REQ-021 On reset low, state = SCAN, cols_n = 4'b1110, key = 8'h00, key_valid = 0, key_held = 0, all counters = 0, synchronizer = 4'b1111.
REQ-022 Reset asserted mid-DEBOUNCE, HELD or RELEASE shall abort with no key_valid pulse; after reset releases, scanning shall restart at column 0.

Structure
REQ-023 Shared package keypad_pkg shall hold the state enum and the key-code width constants (ROW_W = 4, COL_W = 4, KEY_W = 8), both reused by the key-to-digit converter.
REQ-024 One sub-module, sync_2ff, shall implement the parameterized-width 2-flop synchronizer; the FSM, counters and column rotation shall stay in keypad_scanner.

Verification (SCAN_CYCLES = 4, DEBOUNCE_CYCLES = 8)
REQ-025 Clean press: hold row 1 low for 60 cycles while column 2 is driven -> exactly one key_valid pulse with key = 8'b0010_0100; key_held stays high until 8 cycles after the synchronized release.
REQ-026 Bounce: pulse row 0 low for 3 cycles during column 0 -> no key_valid; scanning resumes at column 1; key stays 8'h00.
REQ-027 Multi-row: rows 0 and 3 low together on column 1 -> never captured; columns keep rotating; no key_valid.
REQ-028 Release bounce: release a held key for 3 cycles, press again, then release for 10 cycles -> single key_valid total; key_held drops once.
REQ-029 Second press: after a full release, press row 3 on column 3 -> second key_valid with key = 8'b1000_1000; key holds the previous value until that strobe.
REQ-030 Reset in HELD: drive reset low mid-hold -> outputs match REQ-021 asynchronously; after reset releases, cols_n = 4'b1110 and no spurious key_valid.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and constants for the keypad scanner and the downstream
// key-to-digit converter.
//   kp_state_t        : scanner FSM state encoding
//   ROW_W/COL_W/KEY_W : widths of the one-hot key code {row, column}
//   is_onehot_row()   : true when exactly one row bit is set
package keypad_pkg;

    localparam int ROW_W = 4;
    localparam int COL_W = 4;
    localparam int KEY_W = 8;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    function automatic logic is_onehot_row(input logic [ROW_W-1:0] v);
        return (v != '0) && ((v & (v - ROW_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for asynchronous inputs, parameterized width.
//   clk   : destination clock
//   reset : asynchronous active-low reset, loads RESET_VAL into both stages
//   din   : asynchronous input
//   dout  : synchronized output, two clk cycles of latency
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            dout <= RESET_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// 4x4 matrix keypad scanner with press and release debounce.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   rows_n    : row lines, pulled up, active-low, asynchronous
//   cols_n    : one-cold column drive
//   key       : last accepted key, {row one-hot, column one-hot}
//   key_valid : one-cycle strobe on a newly accepted press
//   key_held  : high from the key_valid cycle until release is debounced
//
// state    | meaning
// ---------+------------------------------------------------------------
// SCAN     | drive a column for SCAN_CYCLES, then sample the rows
// DEBOUNCE | column frozen, captured row must stay stable to accept
// HELD     | key accepted, waiting for all rows to go idle
// RELEASE  | rows idle, must stay idle DEBOUNCE_CYCLES to finish
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROW_W-1:0] rows_n,
    output logic [COL_W-1:0] cols_n,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_held
);

    localparam int SCAN_W = $clog2(SCAN_CYCLES);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [ROW_W-1:0] rows_sync_n;
    logic [ROW_W-1:0] row_pat;
    logic [COL_W-1:0] col_onehot;

    kp_state_t         state_q, state_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [1:0]        col_q, col_d;
    logic [KEY_W-1:0]  cap_q, cap_d;
    logic [KEY_W-1:0]  key_d;
    logic              valid_d;
    logic              held_d;

    sync_2ff #(
        .WIDTH     (ROW_W),
        .RESET_VAL ({ROW_W{1'b1}})
    ) u_sync_rows (
        .clk   (clk),
        .reset (reset),
        .din   (rows_n),
        .dout  (rows_sync_n)
    );

    assign row_pat    = ~rows_sync_n;
    assign col_onehot = COL_W'(1) << col_q;
    assign cols_n     = ~col_onehot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SCAN;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            col_q      <= '0;
            cap_q      <= '0;
            key        <= '0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            col_q      <= col_d;
            cap_q      <= cap_d;
            key        <= key_d;
            key_valid  <= valid_d;
            key_held   <= held_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        col_d      = col_q;
        cap_d      = cap_q;
        key_d      = key;
        valid_d    = 1'b0;
        held_d     = key_held;

        unique case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (is_onehot_row(row_pat)) begin
                        cap_d     = {row_pat, col_onehot};
                        deb_cnt_d = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end

            DEBOUNCE: begin
                if (row_pat == cap_q[KEY_W-1:COL_W]) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        key_d     = cap_q;
                        valid_d   = 1'b1;
                        held_d    = 1'b1;
                        deb_cnt_d = '0;
                        state_d   = HELD;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    end
                end else begin
                    // Bounce or a different key: drop it and keep scanning.
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    col_d      = col_q + 2'd1;
                    state_d    = SCAN;
                end
            end

            HELD: begin
                // Extra keys while held are deliberately ignored.
                if (row_pat == '0) begin
                    deb_cnt_d = '0;
                    state_d   = RELEASE;
                end
            end

            RELEASE: begin
                if (row_pat == '0) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        held_d     = 1'b0;
                        deb_cnt_d  = '0;
                        scan_cnt_d = '0;
                        col_d      = col_q + 2'd1;
                        state_d    = SCAN;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_d = '0;
                    state_d   = HELD;
                end
            end

            default: state_d = SCAN;
        endcase
    end

endmodule
